uart_rx_fifo: RTL and testbench

//  Receive-side byte buffer directly downstream of the UART receiver. Captures each

---
 rtl/uart_rx_fifo_pkg.sv | 35 +++
 rtl/uart_rx_fifo.sv | 155 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_pkg
// Shared definitions for the UART receive-side FIFO:
//   - UART_DATA_W            : width of one received character (8)
//   - RX_FIFO_DEPTH_DEFAULT  : default FIFO depth (16 entries)
//   - RX_FIFO_ADDR_W_DEFAULT : log2 of the default depth
//   - lvl_op_e               : occupancy update selector
//   - sat_inc8()             : saturating 8-bit increment helper
// Optional feature macro used by importers: UART_RX_FIFO_OVR_CNT_EN
// -----------------------------------------------------------------------------
package uart_rx_fifo_pkg;

    localparam int UART_DATA_W            = 8;
    localparam int RX_FIFO_DEPTH_DEFAULT  = 16;
    localparam int RX_FIFO_ADDR_W_DEFAULT = 4;

    // How the occupancy counter moves in a given cycle.
    typedef enum logic [1:0] {
        LVL_HOLD = 2'b00,
        LVL_INC  = 2'b01,
        LVL_DEC  = 2'b10
    } lvl_op_e;

    // Increment an 8-bit value, sticking at 8'hFF instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side byte buffer behind the UART receiver. Each rising edge of the
// receiver's "data complete" flag captures one byte into a power-of-two circular
// FIFO; the head byte is presented first-word-fall-through on a valid/ready port.
// Bytes arriving while the FIFO is full (and nothing leaves that cycle) are
// dropped and flagged by a sticky overrun bit.
//
// Ports:
//   clk        in   1          system clock
//   rst        in   1          asynchronous active-high reset
//   in_data    in   8          received byte
//   in_valid   in   1          receiver complete flag (level, may be held)
//   out_data   out  8          byte at FIFO head (valid while out_valid)
//   out_valid  out  1          FIFO non-empty
//   out_ready  in   1          consumer accepts head when out_valid && out_ready
//   level      out  ADDR_W+1   occupancy 0..DEPTH
//   full       out  1          level == DEPTH
//   overrun    out  1          sticky dropped-byte flag
//   ovr_clr    in   1          clears overrun (a same-cycle drop wins)
//   ovr_count  out  8          only with UART_RX_FIFO_OVR_CNT_EN: saturating
//                              count of dropped bytes, cleared by ovr_clr
//
// Configuration macro: UART_RX_FIFO_OVR_CNT_EN
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = RX_FIFO_DEPTH_DEFAULT,
    parameter int ADDR_W = RX_FIFO_ADDR_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] in_data,
    input  logic                   in_valid,
    output logic [UART_DATA_W-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W:0]        level,
    output logic                   full,
    output logic                   overrun,
`ifdef UART_RX_FIFO_OVR_CNT_EN
    output logic [7:0]             ovr_count,
`endif
    input  logic                   ovr_clr
);

    localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   LEVEL_ZERO = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO   = ADDR_W'(0);

    logic [UART_DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr_r;
    logic [ADDR_W-1:0]      rd_ptr_r;
    logic [ADDR_W:0]        level_r;
    logic                   out_valid_r;
    logic                   full_r;
    logic                   overrun_r;
    logic                   in_valid_q_r;

    logic                   push_s;
    logic                   pop_s;
    logic                   wr_en_s;
    logic                   drop_s;
    lvl_op_e                lvl_op_s;
    logic [ADDR_W:0]        level_next_s;

    // Decode push/pop/drop and the next occupancy for this cycle.
    always_comb begin
        push_s       = in_valid & ~in_valid_q_r;
        pop_s        = out_valid_r & out_ready;
        // A full FIFO still accepts a byte when the head leaves in the same cycle.
        wr_en_s      = push_s & (~full_r | pop_s);
        drop_s       = push_s & full_r & ~pop_s;
        lvl_op_s     = LVL_HOLD;
        level_next_s = level_r;
        if (wr_en_s && !pop_s) begin
            lvl_op_s = LVL_INC;
        end else if (pop_s && !wr_en_s) begin
            lvl_op_s = LVL_DEC;
        end else begin
            lvl_op_s = LVL_HOLD;
        end
        case (lvl_op_s)
            LVL_INC:  level_next_s = level_r + LEVEL_ONE;
            LVL_DEC:  level_next_s = level_r - LEVEL_ONE;
            LVL_HOLD: level_next_s = level_r;
            default:  level_next_s = level_r;
        endcase
    end

    // Pointers, occupancy, status flags and receiver edge-detect register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            level_r      <= LEVEL_ZERO;
            out_valid_r  <= 1'b0;
            full_r       <= 1'b0;
            overrun_r    <= 1'b0;
            in_valid_q_r <= 1'b0;
        end else begin
            in_valid_q_r <= in_valid;
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r     <= level_next_s;
            out_valid_r <= (level_next_s != LEVEL_ZERO);
            full_r      <= (level_next_s == LEVEL_FULL);
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (ovr_clr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    // Byte storage; deliberately not reset, contents are qualified by out_valid.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

`ifdef UART_RX_FIFO_OVR_CNT_EN
    logic [7:0] ovr_count_r;

    // Saturating count of dropped bytes; an increment beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_count_r <= 8'd0;
        end else if (drop_s) begin
            ovr_count_r <= sat_inc8(ovr_count_r);
        end else if (ovr_clr) begin
            ovr_count_r <= 8'd0;
        end
    end

    assign ovr_count = ovr_count_r;
`endif

    // Head byte falls through combinationally from storage.
    assign out_data  = mem_r[rd_ptr_r];
    assign out_valid = out_valid_r;
    assign level     = level_r;
    assign full      = full_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo. The stimulus process holds a reference
// model (a byte queue plus occupancy/overrun state derived from the FIFO rules)
// and pushes every byte the FIFO should accept onto a scoreboard queue. A
// separate monitor pops that queue on each DUT handshake and compares the data.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic [7:0]        in_data;
    logic              in_valid;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W:0]   level;
    logic              full;
    logic              overrun;
    logic              ovr_clr;
`ifdef UART_RX_FIFO_OVR_CNT_EN
    logic [7:0]        ovr_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard of bytes the FIFO must deliver, oldest first.
    logic [7:0] exp_q [$];

    // Reference model state (state after the most recent clock edge).
    int m_level;
    bit m_ovr;
    int m_cnt;
    bit m_prev_v;

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .full      (full),
        .overrun   (overrun),
`ifdef UART_RX_FIFO_OVR_CNT_EN
        .ovr_count (ovr_count),
`endif
        .ovr_clr   (ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake must deliver the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 32'd1, 32'd0);
            end else begin
                chk("pop_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Compare all status outputs against the model.
    task automatic check_state();
        chk("level", {27'd0, level}, 32'(m_level));
        chk("out_valid", {31'd0, out_valid}, {31'd0, (m_level != 0)});
        chk("full", {31'd0, full}, {31'd0, (m_level == DEPTH)});
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
`ifdef UART_RX_FIFO_OVR_CNT_EN
        chk("ovr_count", {24'd0, ovr_count}, 32'(m_cnt));
`endif
        if (m_level != 0 && exp_q.size() != 0) begin
            chk("head_data", {24'd0, out_data}, {24'd0, exp_q[0]});
        end
    endtask

    // Drive one cycle of inputs (just after a rising edge), predict, then check.
    task automatic cycle(input bit v, input logic [7:0] d, input bit rdy, input bit clr);
        bit pop;
        bit push;
        bit drop;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        ovr_clr   = clr;
        pop  = rdy && (m_level != 0);
        push = v && !m_prev_v;
        drop = 1'b0;
        if (push) begin
            if (m_level < DEPTH || pop) begin
                exp_q.push_back(d);
                m_level++;
            end else begin
                drop  = 1'b1;
                m_ovr = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        if (pop) m_level--;
        if (clr && !drop) begin
            m_ovr = 1'b0;
            m_cnt = 0;
        end
        m_prev_v = v;
        @(posedge clk);
        #1;
        check_state();
    endtask

    // Push one byte as a one-cycle pulse followed by an idle cycle.
    task automatic push_byte(input logic [7:0] d, input bit rdy);
        cycle(1'b1, d, rdy, 1'b0);
        cycle(1'b0, d, rdy, 1'b0);
    endtask

    // Assert reset (called just after a rising edge) and check immediate clearing.
    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ovr_clr   = 1'b0;
        in_data   = 8'h00;
        #2;
        exp_q.delete();
        m_level  = 0;
        m_ovr    = 1'b0;
        m_cnt    = 0;
        m_prev_v = 1'b0;
        check_state();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; ovr_clr = 1'b0; in_data = 8'h00;
        @(posedge clk);
        #1;
        do_reset();

        // 1: single push, FWFT presentation, single pop.
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // 2: held in_valid yields exactly one entry.
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        drain();

        // 3: fill to DEPTH, overflow drops, drain in order.
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 1'b0);
        push_byte(8'h10, 1'b0);
        drain();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // 4: full FIFO push + pop in same cycle.
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h80 + i), 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        drain();

        // 5: continuous push/pop of 40 bytes across pointer wrap.
        for (int i = 0; i < 40; i++) push_byte(8'($urandom_range(0, 255)), 1'b1);
        drain();

        // 6: clear racing a drop, clear alone, then reset mid-stream.
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i * 3), 1'b0);
        push_byte(8'hEE, 1'b0);
        cycle(1'b1, 8'hEF, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        do_reset();

        // Randomized traffic with alternating consumer phases.
        for (int i = 0; i < 3000; i++) begin
            bit rdy;
            if ((i / 200) % 2 == 0) rdy = ($urandom_range(0, 3) == 0);
            else                    rdy = ($urandom_range(0, 3) != 0);
            cycle(($urandom_range(0, 1) == 1), 8'($urandom_range(0, 255)), rdy,
                  ($urandom_range(0, 31) == 0));
            if (i == 1500) do_reset();
        end
        drain();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
